// File: rtl/decryption_demux.sv
// Buffers encrypted bytes tagged with an engine select and routes each one,
// in arrival order, to its decryption engine once that engine is idle.
module decryption_demux #(
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select_i,
  input  logic [2:0]         busy_i,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  output logic               full_o,
  output logic               drop_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [D_WIDTH-1:0] dataMem_q [FIFO_DEPTH];
  logic [1:0]         selMem_q  [FIFO_DEPTH];

  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [D_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;
  logic               valid0_q, valid0_d, valid1_q, valid1_d, valid2_q, valid2_d;
  logic               drop_q, drop_d;

  logic               push, pop, engineIdle;
  logic [1:0]         headSel;
  logic [D_WIDTH-1:0] headData;

  assign headSel  = selMem_q[rdPtr_q];
  assign headData = dataMem_q[rdPtr_q];

  // Push uses the registered full flag, so a pop on the same edge cannot free a slot early.
  assign push = valid_i && !full_q;

  always_comb begin
    engineIdle = 1'b0;
    case (headSel)
      2'd0:    engineIdle = !busy_i[0];
      2'd1:    engineIdle = !busy_i[1];
      2'd2:    engineIdle = !busy_i[2];
      default: engineIdle = 1'b1;
    endcase
  end

  assign pop = (count_q != '0) && engineIdle;

  always_comb begin
    wrPtr_d  = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d  = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    data0_d  = data0_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    valid2_d = 1'b0;
    drop_d   = 1'b0;
    if (pop) begin
      case (headSel)
        2'd0:    begin data0_d = headData; valid0_d = 1'b1; end
        2'd1:    begin data1_d = headData; valid1_d = 1'b1; end
        2'd2:    begin data2_d = headData; valid2_d = 1'b1; end
        default: drop_d = 1'b1;
      endcase
    end
  end

  // Storage carries no reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      dataMem_q[wrPtr_q] <= data_i;
      selMem_q[wrPtr_q]  <= select_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      drop_q   <= drop_d;
    end
  end

  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign data2_o  = data2_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;
  assign valid2_o = valid2_q;
  assign full_o   = full_q;
  assign drop_o   = drop_q;

endmodule

// File: tb/tb_decryption_demux.sv
// Directed bench for decryption_demux: routing, stall/full, drop, wrap and
// asynchronous reset behaviour against hand-computed expectations.
module tb_decryption_demux;

  logic       clk;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [1:0] select_i;
  logic [2:0] busy_i;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o;
  logic       full_o, drop_o;

  int testsRun    = 0;
  int testsFailed = 0;

  decryption_demux #(.D_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .select_i (select_i),
    .busy_i   (busy_i),
    .data0_o  (data0_o),
    .data1_o  (data1_o),
    .data2_o  (data2_o),
    .valid0_o (valid0_o),
    .valid1_o (valid1_o),
    .valid2_o (valid2_o),
    .full_o   (full_o),
    .drop_o   (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse vector ordered {valid0, valid1, valid2, drop}
  task automatic checkPulses(input string tag, input logic [3:0] expected);
    checkOutput(tag, {28'd0, valid0_o, valid1_o, valid2_o, drop_o}, {28'd0, expected});
  endtask

  // Drive one cycle of inputs, take the edge, then settle 1ns past it
  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [7:0] d, input logic [2:0] busy);
    valid_i  = v;
    select_i = sel;
    data_i   = d;
    busy_i   = busy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] chanMask(input int sel);
    case (sel)
      0:       return 4'b1000;
      1:       return 4'b0100;
      2:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [7:0] chanData(input int sel);
    case (sel)
      0:       return data0_o;
      1:       return data1_o;
      default: return data2_o;
    endcase
  endfunction

  initial begin
    rst = 1'b1; valid_i = 1'b0; select_i = 2'd0; data_i = 8'h00; busy_i = 3'b000;
    #12;
    checkPulses("reset pulses", 4'b0000);
    checkOutput("reset full", {31'd0, full_o}, 32'd0);
    checkOutput("reset data", {8'd0, data0_o, data1_o, data2_o}, 32'd0);
    rst = 1'b0;

    // Single byte latency
    applyStimulus(1, 0, 8'h41, 3'b000);
    checkPulses("single after push", 4'b0000);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("single pulse", 4'b1000);
    checkOutput("single data0", {24'd0, data0_o}, 32'h41);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("single one cycle", 4'b0000);
    checkOutput("single data0 hold", {24'd0, data0_o}, 32'h41);

    // Back-to-back routing
    applyStimulus(1, 1, 8'h10, 3'b000);
    applyStimulus(1, 2, 8'h20, 3'b000);
    checkPulses("route ch1", 4'b0100);
    checkOutput("route data1", {24'd0, data1_o}, 32'h10);
    applyStimulus(1, 0, 8'h30, 3'b000);
    checkPulses("route ch2", 4'b0010);
    checkOutput("route data2", {24'd0, data2_o}, 32'h20);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("route ch0", 4'b1000);
    checkOutput("route data0", {24'd0, data0_o}, 32'h30);

    // Stall until full, fifth byte lost
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 8'hA1 + 8'(i), 3'b001);
      checkPulses($sformatf("stall quiet %0d", i), 4'b0000);
      checkOutput($sformatf("stall full %0d", i), {31'd0, full_o}, (i >= 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(0, 0, 8'h00, 3'b000);
    for (int i = 0; i < 4; i++) begin
      checkPulses($sformatf("drain pulse %0d", i), 4'b1000);
      checkOutput($sformatf("drain data %0d", i), {24'd0, data0_o}, 32'hA1 + i);
      applyStimulus(0, 0, 8'h00, 3'b000);
    end
    checkPulses("drain fifth lost", 4'b0000);
    checkOutput("drain full clear", {31'd0, full_o}, 32'd0);

    // Invalid select is dropped, next entry still routed
    applyStimulus(1, 3, 8'h55, 3'b000);
    applyStimulus(1, 2, 8'h66, 3'b000);
    checkPulses("drop pulse", 4'b0001);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("drop then ch2", 4'b0010);
    checkOutput("drop data2", {24'd0, data2_o}, 32'h66);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("drop quiet", 4'b0000);

    // Busy head blocks a later entry for an idle engine
    applyStimulus(1, 2, 8'h77, 3'b100);
    applyStimulus(1, 0, 8'h88, 3'b100);
    applyStimulus(0, 0, 8'h00, 3'b100);
    checkPulses("no bypass", 4'b0000);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("unblock ch2", 4'b0010);
    checkOutput("unblock data2", {24'd0, data2_o}, 32'h77);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("unblock ch0", 4'b1000);
    checkOutput("unblock data0", {24'd0, data0_o}, 32'h88);

    // Continuous stream wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 2'(i % 3), 8'(i), 3'b000);
      if (i > 0) begin
        checkPulses($sformatf("wrap pulse %0d", i - 1), chanMask((i - 1) % 3));
        checkOutput($sformatf("wrap data %0d", i - 1), {24'd0, chanData((i - 1) % 3)}, 32'(i - 1));
      end
    end
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("wrap pulse 9", chanMask(0));
    checkOutput("wrap data 9", {24'd0, data0_o}, 32'h09);

    // Asynchronous reset between edges with buffered entries
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'hC1 + 8'(i), 3'b001);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkPulses("async reset pulses", 4'b0000);
    checkOutput("async reset data", {8'd0, data0_o, data1_o, data2_o}, 32'd0);
    checkOutput("async reset full", {31'd0, full_o}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 8'h00, 3'b000);
      checkPulses($sformatf("no stale %0d", i), 4'b0000);
      checkOutput($sformatf("no stale data %0d", i), {24'd0, data0_o}, 32'd0);
    end

    // First edge after reset accepts a push
    applyStimulus(1, 1, 8'h5A, 3'b000);
    applyStimulus(0, 0, 8'h00, 3'b000);
    checkPulses("post reset ch1", 4'b0100);
    checkOutput("post reset data1", {24'd0, data1_o}, 32'h5A);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
